// File: rtl/mc_maindec.sv
// Multicycle main control FSM for the MIPS core: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and aluop. Optional memory handshake under `MEM_READY_EN`.
module mc_maindec (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
`ifdef MEM_READY_EN
  input  logic       mem_ready,
`endif
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       iord,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  state_t state_q, state_d;
  logic   pcwrite, branch, mem_done;

`ifdef MEM_READY_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = S_FETCH;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        // IR/PC load only on the cycle the memory access completes
        irwrite = mem_done;
        pcwrite = mem_done;
        alusrcb = 2'b01;
        state_d = mem_done ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_done ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = mem_done ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pcen = pcwrite | (branch & zero);

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main control FSM for the MIPS core. It sits directly upstream of the ALU decoder: it sequences each instruction through fetch/decode/execute/memory/writeback states, drives all datapath enables and muxes, and produces the 2-bit `aluop` that the ALU decoder expands, together with `funct`, into the 3-bit ALU control.

## Interface
- No parameters. State encoding is fixed (4-bit, listed under Operation).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: opcode from the instruction register, `instr[31:26]`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completion; present only with `MEM_READY_EN`.
- `memwrite`, `irwrite`, `regwrite` out 1: memory write, IR load, and register-file write.
- `regdst`, `memtoreg`, `alusrca`, `iord` out 1: mux selects.
- `alusrcb` out 2: ALU B select. `00` = reg B, `01` = constant 4, `10` = sign-extended imm, `11` = imm<<2.
- `pcsrc` out 2: PC select. `00` = ALU result, `01` = ALUOut, `10` = jump target.
- `aluop` out 2: to ALU decoder. `00` = add, `01` = sub, `10` = use funct.
- `pcen` out 1: PC enable, `pcwrite | (branch & zero)`.
- `illegal` out 1: unsupported opcode seen in DECODE.

## Operation
- State register with encodings: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPEEX=7, RTYPEWB=8, BEQEX=9, ADDIEX=10, ADDIWB=11, JEX=12. Codes 13–15 go to FETCH with all outputs 0.
- Outputs are Moore, decoded from state. Exceptions: `pcen` also depends on `zero`; `illegal` also depends on `op`. Any output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01. Next state is DECODE.
- DECODE: `alusrcb`=11. Next state by `op`:
  - `100011` (lw) or `101011` (sw): MEMADR.
  - `000000`: RTYPEEX.
  - `000100`: BEQEX.
  - `001000`: ADDIEX.
  - `000010`: JEX.
  - Anything else: FETCH, with `illegal`=1 for this cycle only.
- MEMADR: `alusrca`=1, `alusrcb`=10. Next state is MEMRD for lw, MEMWR for sw (decided on the `op` held in IR).
- MEMRD: `iord`=1. Next state is MEMWB.
- MEMWB: `memtoreg`=1, `regwrite`=1. Next state is FETCH.
- MEMWR: `iord`=1, `memwrite`=1. Next state is FETCH.
- RTYPEEX: `alusrca`=1, `aluop`=10. Next state is RTYPEWB.
- RTYPEWB: `regdst`=1, `regwrite`=1. Next state is FETCH.
- BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, internal `branch`=1. Next state is FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10. Next state is ADDIWB.
- ADDIWB: `regwrite`=1. Next state is FETCH.
- JEX: `pcsrc`=10, `pcwrite`=1. Next state is FETCH.

## Timing
- `rst_n` low forces RESET immediately (asynchronous). All outputs are 0 while it is low, including when asserted mid-instruction; the in-flight instruction is abandoned.
- After `rst_n` rises, the first clock edge moves RESET to FETCH. The second edge loads IR and PC+4.
- Cycles per instruction (without `MEM_READY_EN`): lw 5; sw, R-type and addi 4; beq and j 3; illegal opcode 2.
- `pcen` is combinational in BEQEX. The branch is taken iff `zero`=1 in that cycle.
- `aluop` is valid in the same cycle as the state that uses it. The ALU decoder is purely combinational, so there is no extra latency.

## Configuration
- `MEM_READY_EN` defined:
  - Adds the `mem_ready` input.
  - FETCH, MEMRD and MEMWR hold their state while `mem_ready`=0.
  - In FETCH, `irwrite` and `pcwrite` equal `mem_ready`, so they fire only on the completing cycle.
  - `memwrite` and `iord` stay high for the whole MEMWR/MEMRD stall.
  - `mem_ready` is ignored in all other states.
- `MEM_READY_EN` undefined: no `mem_ready` port; every state lasts exactly one cycle.

## Test plan
- Reset: drive `rst_n`=0 mid-MEMWR → `memwrite` drops to 0 within the same cycle. Release → FETCH after one edge with `irwrite`=`pcwrite`=`pcen`=1, `alusrcb`=01.
- lw (`op`=100011): state sequence 1,2,3,4,5,1. `memtoreg`=`regwrite`=1 only in state 5. `aluop`=00 throughout.
- R-type (`op`=000000): `aluop`=10 in RTYPEEX only. `regdst`=1 with `regwrite`=1 in RTYPEWB. Total 4 cycles.
- beq (`op`=000100): with `zero`=1, `pcen`=1 and `pcsrc`=01 in BEQEX; with `zero`=0, `pcen`=0. Both return to FETCH.
- Illegal (`op`=111111) → `illegal`=1 for one DECODE cycle, then FETCH, with no `regwrite`/`memwrite` pulses. j (`op`=000010) → `pcsrc`=10, `pcen`=1 in JEX.
- With `MEM_READY_EN`: hold `mem_ready`=0 for 3 cycles in FETCH → state stays 1 with `irwrite`=0. Assert `mem_ready` → `irwrite`=1 for one cycle, then DECODE.
